// File: rtl/dft_pkg.sv
// Shared definitions for the scan pattern driver: FSM states and counter sizing.
package dft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    REPORT
  } dft_state_t;

  // Bits needed to count 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, serial-in/serial-out shift register. Shifts toward bit 0;
// the serial input enters at the top bit.
module scan_shift_reg #(
  parameter int unsigned CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 sin,
  input  logic [CHAIN_LEN-1:0] din,
  output logic [CHAIN_LEN-1:0] q
);

  logic [CHAIN_LEN-1:0] shifted;

  // Next value on a shift; written without a part-select so CHAIN_LEN=1 works.
  always_comb begin
    shifted                = q >> 1;
    shifted[CHAIN_LEN-1]   = sin;
  end

  // Register: load wins over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/scan_pattern_driver.sv
// Scan test driver: loads a pattern into a downstream chain, runs capture,
// unloads the response, compares it under mask and counts failures.
module scan_pattern_driver
  import dft_pkg::*;
#(
  parameter int unsigned CHAIN_LEN      = 8,
  parameter int unsigned CAPTURE_CYCLES = 1,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] pat_expect,
  input  logic [CHAIN_LEN-1:0] pat_mask,
  input  logic                 fail_clr,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 res_valid,
  output logic [CHAIN_LEN-1:0] res_data,
  output logic                 res_pass,
  output logic [CNT_W-1:0]     fail_count,
  output logic                 busy
);

  // One phase counter serves LOAD, CAPTURE and UNLOAD, so it must also cover
  // CAPTURE_CYCLES when that exceeds the chain length.
  localparam int unsigned CW = (cnt_width(CHAIN_LEN) > cnt_width(CAPTURE_CYCLES)) ?
                               cnt_width(CHAIN_LEN) : cnt_width(CAPTURE_CYCLES);
  localparam logic [CW-1:0]    LEN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0]    CAP_LAST = CW'(CAPTURE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  dft_state_t           state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 accept, phase_done;
  logic [CHAIN_LEN-1:0] exp_q, mask_q, stim_q, des_q, unload_word;
  logic                 unused_ok;

  // Stimulus serialiser: bit 0 is presented first; zeros refill behind it so
  // scan_in returns to 0 on its own once LOAD completes.
  scan_shift_reg #(.CHAIN_LEN(CHAIN_LEN)) u_stim (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state == LOAD),
    .sin   (1'b0),
    .din   (pat_data),
    .q     (stim_q)
  );

  // Response deserialiser: first unloaded bit ends up in bit 0.
  scan_shift_reg #(.CHAIN_LEN(CHAIN_LEN)) u_resp (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .shift (state == UNLOAD),
    .sin   (scan_out),
    .din   ('0),
    .q     (des_q)
  );

  assign scan_in   = stim_q[0];
  // Only stim_q[0] drives logic; the reduction keeps the remaining bits referenced.
  assign unused_ok = ^{stim_q, des_q};

  // Full response word including the bit sampled on the final UNLOAD edge.
  always_comb begin
    unload_word              = des_q >> 1;
    unload_word[CHAIN_LEN-1] = scan_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    phase_done = 1'b0;
    accept     = 1'b0;
    pat_ready  = 1'b0;
    scan_en    = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        pat_ready = 1'b1;
        busy      = 1'b0;
        accept    = pat_valid;
        if (pat_valid) state_nxt = LOAD;
      end
      LOAD: begin
        scan_en = 1'b1;
        if (cnt == LEN_LAST) begin
          phase_done = 1'b1;
          state_nxt  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (cnt == CAP_LAST) begin
          phase_done = 1'b1;
          state_nxt  = UNLOAD;
        end
      end
      UNLOAD: begin
        scan_en = 1'b1;
        if (cnt == LEN_LAST) begin
          phase_done = 1'b1;
          state_nxt  = REPORT;
        end
      end
      REPORT: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter: counts within a phase, returns to 0 on every phase exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (phase_done) begin
      cnt <= '0;
    end else if (state == LOAD || state == CAPTURE || state == UNLOAD) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Latch expected response and mask for the accepted pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      exp_q  <= pat_expect;
      mask_q <= pat_mask;
    end
  end

  // Result fields update on the last UNLOAD edge and hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_pass <= 1'b0;
    end else if (state == UNLOAD && phase_done) begin
      res_data <= unload_word;
      res_pass <= ((unload_word ^ exp_q) & mask_q) == '0;
    end
  end

  // Saturating failure counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_count <= '0;
    end else if (fail_clr) begin
      fail_count <= '0;
    end else if (state == REPORT && !res_pass && fail_count != CNT_MAX) begin
      fail_count <= fail_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Scoreboard bench for scan_pattern_driver with a loopback chain model.
module tb_scan_pattern_driver;

  localparam int N      = 8;
  localparam int C      = 1;
  localparam int CW     = 2;
  localparam int FC_MAX = (1 << CW) - 1;
  localparam int LAT    = 2 * N + C;

  logic          clk = 1'b0;
  logic          rst;
  logic          pat_valid, pat_ready;
  logic [N-1:0]  pat_data, pat_expect, pat_mask;
  logic          fail_clr;
  logic          scan_en, scan_in, scan_out;
  logic          res_valid, res_pass, busy;
  logic [N-1:0]  res_data;
  logic [CW-1:0] fail_count;

  scan_pattern_driver #(.CHAIN_LEN(N), .CAPTURE_CYCLES(C), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_data   (pat_data),
    .pat_expect (pat_expect),
    .pat_mask   (pat_mask),
    .fail_clr   (fail_clr),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_pass   (res_pass),
    .fail_count (fail_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream chain: N flops shifting toward scan_out while scan_en is high.
  logic [N-1:0] chain = '0;
  always @(posedge clk) if (scan_en) chain <= {scan_in, chain[N-1:1]};
  assign scan_out = chain[0];

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [N-1:0] data;
    bit           pass;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  int   fc_model = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle timing model of an outstanding pattern plus result checks.
  always @(negedge clk) begin
    bit   rdy_exp, en_exp, sin_exp, rv_exp, popped_fail;
    int   d;
    exp_t e;
    if (rst) begin
      sb.delete();
      fc_model = 0;
    end else begin
      rdy_exp = (sb.size() == 0);
      d       = rdy_exp ? -1 : (cyc - sb[0].acc);
      en_exp  = (d >= 0 && d < N) || (d >= N + C && d < LAT);
      sin_exp = (d >= 0 && d < N) ? sb[0].data[d] : 1'b0;
      rv_exp  = (d == LAT);
      chk("pat_ready", {31'd0, pat_ready}, {31'd0, rdy_exp});
      chk("busy", {31'd0, busy}, {31'd0, !rdy_exp});
      chk("scan_en", {31'd0, scan_en}, {31'd0, en_exp});
      chk("scan_in", {31'd0, scan_in}, {31'd0, sin_exp});
      chk("res_valid", {31'd0, res_valid}, {31'd0, rv_exp});
      chk("fail_count", {30'd0, fail_count}, fc_model);
      popped_fail = 1'b0;
      if (rv_exp) begin
        e = sb.pop_front();
        chk("res_data", {24'd0, res_data}, {24'd0, e.data});
        chk("res_pass", {31'd0, res_pass}, {31'd0, e.pass});
        popped_fail = !e.pass;
      end else if (d > LAT) begin
        e = sb.pop_front();
        chk("result_timeout", 32'd0, 32'd1);
      end
      if (fail_clr)         fc_model = 0;
      else if (popped_fail) fc_model = (fc_model < FC_MAX) ? fc_model + 1 : FC_MAX;
      if (pat_valid && rdy_exp) begin
        // Loopback chain: the unloaded response equals the loaded stimulus.
        e.data = pat_data;
        e.pass = ((pat_data ^ pat_expect) & pat_mask) == '0;
        e.acc  = cyc + 1;
        sb.push_back(e);
        accepts++;
      end
    end
  end

  task automatic send(input logic [N-1:0] d, input logic [N-1:0] x, input logic [N-1:0] m);
    int n;
    @(posedge clk); #1;
    pat_valid = 1'b1; pat_data = d; pat_expect = x; pat_mask = m;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!pat_ready && n < 100);
    if (!pat_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    pat_valid  = 1'b0;
    pat_data   = N'($urandom);
    pat_expect = N'($urandom);
    pat_mask   = N'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 fail_clr = 1'b1;
    @(posedge clk); #1 fail_clr = 1'b0;
  endtask

  initial begin
    int start;
    logic [N-1:0] d, m;
    rst = 1'b1; pat_valid = 1'b0; pat_data = '0; pat_expect = '0; pat_mask = '0; fail_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Loopback pass, masked miscompare, unmasked miscompare, all-zero mask.
    send(8'hA5, 8'hA5, 8'hFF); drain();
    send(8'h3C, 8'h3D, 8'hFE); drain();
    send(8'h3C, 8'h3D, 8'hFF); drain();
    send(8'h5A, 8'hA5, 8'h00); drain();

    // Saturation from zero, then a clear coinciding with a failing REPORT.
    pulse_clr();
    for (int i = 0; i < 5; i++) send(8'h00, 8'hFF, 8'hFF);
    drain();
    send(8'h0F, 8'hF0, 8'hFF);
    repeat (LAT) @(posedge clk);
    #1 fail_clr = 1'b1;
    @(posedge clk); #1 fail_clr = 1'b0;
    drain();

    // Reset in the middle of UNLOAD, then a normal pattern.
    send(8'hC3, 8'hC3, 8'hFF);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(8'h96, 8'h96, 8'hFF); drain();

    // pat_valid held high through three patterns.
    start = accepts;
    @(posedge clk); #1;
    pat_valid = 1'b1; pat_data = N'($urandom); pat_expect = N'($urandom); pat_mask = N'($urandom);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (accepts - start >= 3) break;
      pat_data = N'($urandom); pat_expect = N'($urandom); pat_mask = N'($urandom);
    end
    pat_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    chk("held_valid_accepts", accepts - start, 32'd3);

    // Randomized patterns with occasional clears.
    for (int i = 0; i < 25; i++) begin
      d = N'($urandom);
      m = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 1) == 1) send(d, d, m);
      else                            send(d, d ^ N'(1 << $urandom_range(0, N - 1)), m);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 7) == 0) begin
        drain();
        pulse_clr();
      end
    end
    drain();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
